// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared definitions for the CNN layer sequencer.
//   - seq_state_e : sequencer FSM states
//   - STG_*       : stage indices in execution order (index 0 runs first)
//   - DEFAULT_*   : default sizing for the sequencer and its watchdog
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_TX_WAIT = 3'd3,
    ST_ERROR   = 3'd4
  } seq_state_e;

  localparam int STG_CONV   = 0;
  localparam int STG_RELU   = 1;
  localparam int STG_POOL   = 2;
  localparam int STG_FLAT   = 3;
  localparam int STG_DENSE  = 4;
  localparam int STG_ARGMAX = 5;

  localparam int DEFAULT_NUM_STAGES     = STG_ARGMAX + 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;

endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: per-stage timeout counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (asserted in the stage's start cycle)
//   enable     : count this cycle (stage is waiting for its done)
//   expired    : the count reaches TIMEOUT_CYCLES-1 on this clock edge
module stage_watchdog
  import cnn_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The start cycle itself counts as the first elapsed cycle, so clear
  // loads 1 and the count equals cycles since the start pulse.
  localparam logic [TO_W-1:0] LAST_OK = TO_W'(TIMEOUT_CYCLES - 2);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= TO_W'(1);
    end else if (enable && (count != '1)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = enable && (count == LAST_OK);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: frame-level scheduler for the CNN datapath.
// Starts each stage in order (conv, relu, pool, flat, dense, argmax), waits
// for its done, publishes one-hot buffer ownership, guards each stage with a
// watchdog, queues one early frame and launches the result byte on the UART.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   frame_loaded_i  : pulse, input frame written to IFMAP
//   stage_done_i    : per-stage done pulses
//   stage_start_o   : per-stage start pulses
//   owner_o         : one-hot buffer owner, zero when nobody owns
//   tx_busy_i       : UART transmitter busy
//   tx_start_o      : pulse, send result byte
//   clear_err_i     : leave ERROR
//   busy_o          : frame in flight (START/WAIT/TX_WAIT)
//   err_o           : sticky watchdog error
//   err_stage_o     : index of the stage that timed out
//   overrun_o       : sticky, frame dropped because one was already pending
//   perf_cycles_o   : cycles of last completed frame
//
// Optional feature: define CNN_SEQ_PERF_EN to build the frame cycle counter;
// otherwise perf_cycles_o is tied to zero.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES) + 1,
  parameter int SIDX_W         = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_loaded_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  output logic [NUM_STAGES-1:0] stage_start_o,
  output logic [NUM_STAGES-1:0] owner_o,
  input  logic                  tx_busy_i,
  output logic                  tx_start_o,
  input  logic                  clear_err_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [SIDX_W-1:0]     err_stage_o,
  output logic                  overrun_o,
  output logic [31:0]           perf_cycles_o
);

  localparam logic [SIDX_W-1:0]     FIRST_IDX = SIDX_W'(STG_CONV);
  localparam logic [SIDX_W-1:0]     LAST_IDX  = SIDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  seq_state_e        state;
  logic [SIDX_W-1:0] idx;
  logic              pending;

  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic              cur_done;
  logic [SIDX_W-1:0] next_idx;
  logic              tx_exit;
  logic              frame_queued;

  assign cur_done     = stage_done_i[idx];
  assign next_idx     = idx + SIDX_W'(1);
  assign wd_clear     = (state == ST_START);
  assign wd_enable    = (state == ST_WAIT);
  // tx_start_o is high for exactly one TX_WAIT cycle; that cycle is the exit.
  assign tx_exit      = (state == ST_TX_WAIT) && tx_start_o;
  // A frame arriving on the exit cycle is handled like an already pending one.
  assign frame_queued = pending || frame_loaded_i;

  stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Outputs are set on the edge that enters a state, so a start pulse and
  // its owner handoff appear in the same cycle as the START state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= FIRST_IDX;
      pending       <= 1'b0;
      stage_start_o <= '0;
      owner_o       <= '0;
      tx_start_o    <= 1'b0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      err_stage_o   <= '0;
      overrun_o     <= 1'b0;
    end else begin
      stage_start_o <= '0;
      tx_start_o    <= 1'b0;

      // One frame may wait while another is in flight; a second one is lost.
      if (busy_o && frame_loaded_i && !tx_exit) begin
        if (pending) overrun_o <= 1'b1;
        else         pending   <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_queued) begin
            state         <= ST_START;
            idx           <= FIRST_IDX;
            stage_start_o <= STAGE_ONE << FIRST_IDX;
            owner_o       <= STAGE_ONE << FIRST_IDX;
            busy_o        <= 1'b1;
            pending       <= pending && frame_loaded_i;
          end
        end

        ST_START: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A done on the expiry cycle takes priority over the timeout.
          if (cur_done) begin
            if (idx != LAST_IDX) begin
              state         <= ST_START;
              idx           <= next_idx;
              stage_start_o <= STAGE_ONE << next_idx;
              owner_o       <= STAGE_ONE << next_idx;
            end else begin
              state      <= ST_TX_WAIT;
              owner_o    <= '0;
              tx_start_o <= !tx_busy_i;
            end
          end else if (wd_expired) begin
            state       <= ST_ERROR;
            owner_o     <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b1;
            err_stage_o <= idx;
          end
        end

        ST_TX_WAIT: begin
          if (tx_start_o) begin
            idx <= FIRST_IDX;
            if (frame_queued) begin
              state         <= ST_START;
              stage_start_o <= STAGE_ONE << FIRST_IDX;
              owner_o       <= STAGE_ONE << FIRST_IDX;
              pending       <= pending && frame_loaded_i;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end else if (!tx_busy_i) begin
            tx_start_o <= 1'b1;
          end
        end

        ST_ERROR: begin
          if (clear_err_i) begin
            state   <= ST_IDLE;
            idx     <= FIRST_IDX;
            err_o   <= 1'b0;
            pending <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          owner_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CNN_SEQ_PERF_EN
  // Counts from the first stage's START cycle up to the tx_start_o cycle.
  logic [31:0] frame_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cycles  <= '0;
      perf_cycles_o <= '0;
    end else begin
      if ((state == ST_START) && (idx == FIRST_IDX)) begin
        frame_cycles <= 32'd1;
      end else if (busy_o && (frame_cycles != 32'hFFFF_FFFF)) begin
        frame_cycles <= frame_cycles + 32'd1;
      end
      if (tx_start_o) perf_cycles_o <= frame_cycles;
    end
  end
`else
  assign perf_cycles_o = '0;
`endif

  owner_onehot_a : assert property (@(posedge clk) disable iff (reset) $onehot0(owner_o));

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
module tb_cnn_layer_sequencer;

  localparam int NS  = 6;
  localparam int TO  = 16;
  localparam int SW  = 3;
  localparam int TXK = 6;  // event kind for tx_start_o

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_loaded_i;
  logic [NS-1:0] stage_done_i;
  logic [NS-1:0] stage_start_o;
  logic [NS-1:0] owner_o;
  logic          tx_busy_i;
  logic          tx_start_o;
  logic          clear_err_i;
  logic          busy_o;
  logic          err_o;
  logic [SW-1:0] err_stage_o;
  logic          overrun_o;
  logic [31:0]   perf_cycles_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard entries: {event kind[31:28], cycle[27:0]}; kind 0..5 = stage
  // start, 6 = tx_start.
  logic [31:0] exp_q[$];

  typedef struct {
    int delay;       // cycles from each start pulse to its done
    int busy;        // cycles tx_busy_i is held high from the last done
    int spurious;    // inject stage_done_i[3] while stage 1 runs
    int exp_cycles;  // expected first-start-to-tx_start cycles
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_loaded_i (frame_loaded_i),
    .stage_done_i   (stage_done_i),
    .stage_start_o  (stage_start_o),
    .owner_o        (owner_o),
    .tx_busy_i      (tx_busy_i),
    .tx_start_o     (tx_start_o),
    .clear_err_i    (clear_err_i),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .err_stage_o    (err_stage_o),
    .overrun_o      (overrun_o),
    .perf_cycles_o  (perf_cycles_o)
  );

  function automatic logic [31:0] ev(input int kind, input int c);
    return {4'(kind), 28'(c)};
  endfunction

  function automatic logic [31:0] perf_exp(input int frame_cycles);
`ifdef CNN_SEQ_PERF_EN
    return 32'(frame_cycles);
`else
    return 32'(frame_cycles) & 32'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic sb_compare(input int kind);
    logic [31:0] want;
    logic [NS-1:0] one;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected at cycle %0d: got kind %0d with nothing expected", cyc, kind);
    end else begin
      want = exp_q.pop_front();
      check("sb_event", ev(kind, cyc), want);
      one = '0;
      if (want[31:28] < 4'(NS)) one[want[31:28]] = 1'b1;
      check("sb_owner", 32'(owner_o), 32'(one));
    end
  endtask

  task automatic sb_sample();
    if (stage_start_o != '0) begin
      check("start_count", $countones(stage_start_o), 1);
      for (int k = 0; k < NS; k++) if (stage_start_o[k]) sb_compare(k);
    end
    if (tx_start_o) sb_compare(TXK);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sb_sample();
  endtask

  // Timed driver: the frame begins in the current cycle t; done pulses follow
  // the bench's own schedule, and expected events are queued as they are caused.
  task automatic run_frame(input int d, input int b, input int xa, input int xb,
                           input bit drive_load, input int spurious, input int exp_cycles);
    int t, u, tx_c;
    t    = cyc;
    u    = t + 1 + 5 * (d + 1) + d;
    tx_c = t + 1 + 6 * (d + 1) + b;
    exp_q.push_back(ev(0, t + 1));
    while (cyc < tx_c) begin
      frame_loaded_i = (drive_load && cyc == t) || (xa != 0 && cyc == t + xa) ||
                       (xb != 0 && cyc == t + xb);
      stage_done_i = '0;
      for (int k = 0; k < NS; k++) begin
        if (cyc == t + 1 + k * (d + 1) + d) begin
          stage_done_i[k] = 1'b1;
          if (k < NS - 1) exp_q.push_back(ev(k + 1, cyc + 1));
          else            exp_q.push_back(ev(TXK, t + 1 + exp_cycles));
        end
      end
      if (spurious != 0 && cyc == t + d + 3) stage_done_i[3] = 1'b1;
      tx_busy_i = (b > 0) && (cyc >= u) && (cyc < u + b);
      step();
      if (xa != 0 && cyc == t + xa + 1) check("overrun_after_pending", 32'(overrun_o), 0);
      if (xb != 0 && cyc == t + xb + 1) check("overrun_after_drop", 32'(overrun_o), 1);
    end
    frame_loaded_i = 1'b0;
    stage_done_i   = '0;
    tx_busy_i      = 1'b0;
    check("busy_at_tx", 32'(busy_o), 1);
    check("owner_at_tx", 32'(owner_o), 0);
  endtask

  task automatic check_idle(input string tag, input int frame_cycles);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_owner"}, 32'(owner_o), 0);
    check({tag, "_err"}, 32'(err_o), 0);
    check({tag, "_perf"}, perf_cycles_o, perf_exp(frame_cycles));
  endtask

  initial begin
    vecs[0] = '{5, 0, 0, 36};    // nominal frame
    vecs[1] = '{1, 0, 0, 12};    // shortest legal stages
    vecs[2] = '{14, 0, 0, 90};   // every done lands on the watchdog expiry cycle
    vecs[3] = '{5, 0, 1, 36};    // stray done for stage 3 during stage 1
    vecs[4] = '{2, 100, 0, 118}; // transmitter busy for 100 cycles

    reset          = 1'b1;
    frame_loaded_i = 1'b0;
    stage_done_i   = '0;
    tx_busy_i      = 1'b0;
    clear_err_i    = 1'b0;

    step();
    check("rst_start", 32'(stage_start_o), 0);
    check("rst_owner", 32'(owner_o), 0);
    check("rst_tx", 32'(tx_start_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_err_stage", 32'(err_stage_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_perf", perf_cycles_o, 0);
    reset = 1'b0;
    while (cyc < 10) step();

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].delay, vecs[i].busy, 0, 0, 1'b1, vecs[i].spurious, vecs[i].exp_cycles);
      stage_done_i = '1;  // done pulses outside WAIT must be ignored
      step();
      stage_done_i = '0;
      check_idle("frame", vecs[i].exp_cycles);
      step();
      step();
    end

    // Watchdog: stage 2 never finishes.
    begin
      int t;
      t = cyc;
      exp_q.push_back(ev(0, t + 1));
      while (cyc < t + 27) begin
        frame_loaded_i = (cyc == t);
        stage_done_i   = '0;
        if (cyc == t + 6)  begin stage_done_i[0] = 1'b1; exp_q.push_back(ev(1, t + 7));  end
        if (cyc == t + 12) begin stage_done_i[1] = 1'b1; exp_q.push_back(ev(2, t + 13)); end
        step();
      end
      frame_loaded_i = 1'b0;
      stage_done_i   = '0;
      check("to_err_before", 32'(err_o), 0);
      check("to_owner_before", 32'(owner_o), 32'h4);
      step();
      check("to_err", 32'(err_o), 1);
      check("to_err_stage", 32'(err_stage_o), 2);
      check("to_owner", 32'(owner_o), 0);
      check("to_busy", 32'(busy_o), 0);
      frame_loaded_i = 1'b1;  // ignored in ERROR
      step();
      frame_loaded_i = 1'b0;
      step();
      step();
      check("err_hold_busy", 32'(busy_o), 0);
      check("err_hold", 32'(err_o), 1);
      clear_err_i = 1'b1;
      step();
      clear_err_i = 1'b0;
      check("clr_err", 32'(err_o), 0);
      check("clr_err_stage", 32'(err_stage_o), 2);
      step();
      run_frame(5, 0, 0, 0, 1'b1, 0, 36);
      step();
      check_idle("after_err", 36);
      step();
    end

    // Queueing: one frame pending, the next one dropped, one extra frame runs.
    run_frame(3, 0, 5, 12, 1'b1, 0, 24);
    run_frame(3, 0, 0, 0, 1'b0, 0, 24);
    step();
    check_idle("after_queue", 24);
    for (int i = 0; i < 10; i++) step();

    // Asynchronous reset between edges while a stage is running.
    begin
      int t;
      t = cyc;
      frame_loaded_i = 1'b1;
      exp_q.push_back(ev(0, t + 1));
      step();
      frame_loaded_i = 1'b0;
      step();
      step();
      check("pre_rst_busy", 32'(busy_o), 1);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_owner", 32'(owner_o), 0);
      check("async_rst_busy", 32'(busy_o), 0);
      check("async_rst_overrun", 32'(overrun_o), 0);
      check("async_rst_perf", perf_cycles_o, 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("post_rst_busy", 32'(busy_o), 0);
      run_frame(2, 0, 0, 0, 1'b1, 0, 18);
      step();
      check_idle("post_rst", 18);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
